uart_tx: RTL and testbench

UART transmitter. It serialises parallel bytes onto the `tx` line and is the transmit half of the UART controller, with its frame format matching the `rx` receiver. Bit timing comes from the shared baud clock `bclk`, which is sampled in the `clk` domain. A one-entry holding register sits in front of the shift register, so a following byte can be queued while the current frame is on the line.

---
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: serialises DATA_BITS-wide words as start, data MSB-first, optional parity, stop bit(s).
// Latency: a frame starts on the first baud tick after the word lands in the holding register.
// Backpressure: din_rdy is low while the one-entry holding register is full; din_vld is ignored then.
//
// Ports:
//   clk, rst       system clock (posedge) and asynchronous active-low reset
//   bclk           baud clock level; a rising edge seen in the clk domain is one bit tick
//   din/din_vld    word to send and its valid; taken when din_vld && din_rdy
//   din_rdy        holding register empty
//   tx             registered serial line, idle high
//   tx_busy        frame in progress
//   tx_done        one-clk pulse on the tick that ends the last stop bit
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic [2:0]           state;
  logic                 bclk_q;
  logic [DATA_BITS-1:0] holding;
  logic [DATA_BITS-1:0] shifter;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;

  logic tick;
  logic frame_end;
  logic load;
  logic take;

  assign tick      = bclk & ~bclk_q;
  assign frame_end = tick && (state == STOP) && (stop_cnt == LAST_STOP);
  // Load decisions use the pre-edge holding flag, so a word accepted on a
  // tick edge waits for the next tick.
  assign load      = !din_rdy && ((tick && (state == IDLE)) || frame_end);
  assign take      = din_vld && din_rdy;
  assign tx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bclk_q   <= 1'b0;
      holding  <= '0;
      shifter  <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= 4'd0;
      stop_cnt <= 1'b0;
      din_rdy  <= 1'b1;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      bclk_q  <= bclk;
      tx_done <= frame_end;

      if (take) begin
        holding <= din;
      end

      // A refill on the same edge as a load keeps the holding register full.
      if (take) begin
        din_rdy <= 1'b0;
      end else if (load) begin
        din_rdy <= 1'b1;
      end

      if (load) begin
        // Entered from IDLE or straight from the final stop bit (no idle gap).
        tx      <= 1'b0;
        shifter <= holding;
        par_bit <= (PARITY == 2) ? ~^holding : ^holding;
        state   <= START;
      end else if (tick) begin
        case (state)
          START: begin
            tx      <= shifter[DATA_BITS-1];
            shifter <= shifter << 1;
            bit_cnt <= 4'd1;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt < LAST_DATA) begin
              tx      <= shifter[DATA_BITS-1];
              shifter <= shifter << 1;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (PARITY != 0) begin
              tx    <= par_bit;
              state <= PAR;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
          PAR: begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            if (stop_cnt == LAST_STOP) begin
              state <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          IDLE: begin
            // Nothing queued: line stays high.
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters with different frame formats share one baud clock.
// Each channel has an expected-word queue filled at handshake time and a line receiver
// that rebuilds frames from the tx level at every tick and compares against the queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk;
  logic       bclk_freeze = 1'b0;
  logic [7:0] din_a [3];
  logic [2:0] din_vld;
  wire  [2:0] din_rdy;
  wire  [2:0] tx;
  wire  [2:0] tx_busy;
  wire  [2:0] tx_done;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din_a[0]), .din_vld(din_vld[0]),
    .din_rdy(din_rdy[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din_a[1]), .din_vld(din_vld[1]),
    .din_rdy(din_rdy[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_tx #(.DATA_BITS(6), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din_a[2][5:0]), .din_vld(din_vld[2]),
    .din_rdy(din_rdy[2]), .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  // Frame format of each channel, mirroring the instance parameters above.
  function automatic int db_of(input int ch);
    return (ch == 2) ? 6 : 8;
  endfunction
  function automatic int par_of(input int ch);
    return ch;
  endfunction
  function automatic int sb_of(input int ch);
    return (ch == 1) ? 2 : 1;
  endfunction
  function automatic logic [7:0] mask_of(input int ch);
    return 8'((1 << db_of(ch)) - 1);
  endfunction

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [3][$];
  int         sent     [3] = '{0, 0, 0};
  int         lost     [3] = '{0, 0, 0};
  int         done_cnt [3] = '{0, 0, 0};
  int         started  [3] = '{0, 0, 0};
  int         last_gap [3] = '{0, 0, 0};
  int         last_end [3] = '{0, 0, 0};
  int         glitch = 0;

  bit         tick_now = 1'b0;
  logic       bclk_prev = 1'b0;
  int         tick_no = 0;

  task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", name, ch, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name, input int ch);
    checks++;
    errors++;
    $display("FAIL %s ch%0d: wait bound expired at %0t", name, ch, $time);
  endtask

  // Baud clock with random half periods; frozen level while bclk_freeze is set.
  initial begin
    int h;
    bclk = 1'b0;
    forever begin
      h = $urandom_range(5, 2);
      repeat (h) @(negedge clk);
      if (!bclk_freeze) bclk = ~bclk;
    end
  end

  // Tick as seen by the transmitter: a rising bclk level compared with last cycle,
  // with the remembered level forced low while reset is held.
  always @(posedge clk) begin
    tick_now  = rst && bclk && !bclk_prev;
    bclk_prev = rst ? bclk : 1'b0;
    if (tick_now) tick_no++;
  end

  // Line integrity: outside ticks the line must not move and tx_done must stay low.
  logic [2:0] last_tx = 3'b111;
  bit         rst_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < 3; c++) begin
      if (rst && rst_prev && !tick_now && (tx[c] !== last_tx[c])) glitch++;
      if (!tick_now && (tx_done[c] !== 1'b0)) glitch++;
      if (tx_done[c] === 1'b1) done_cnt[c]++;
    end
    last_tx  = tx;
    rst_prev = rst;
  end

  task automatic wait_tick(input int ch, output bit ok);
    int n = 0;
    ok = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) return;
      if (tick_now) begin
        ok = 1'b1;
        return;
      end
      n++;
      if (n > 300) begin
        bound_fail("tick_timeout", ch);
        return;
      end
    end
  endtask

  // Receives one frame whose start bit was sampled on the current tick.
  task automatic rx_frame(input int ch);
    bit         ok;
    logic [7:0] data;
    logic [7:0] e;
    logic       pbit;
    int         st  = tick_no;
    int         db  = db_of(ch);
    int         par = par_of(ch);
    int         sb  = sb_of(ch);
    started[ch]++;
    chk("busy_at_start", ch, tx_busy[ch], 1);
    data = 8'h00;
    pbit = 1'b0;
    for (int i = 0; i < db; i++) begin
      wait_tick(ch, ok);
      if (!ok) return;
      data = {data[6:0], tx[ch]};
    end
    if (par != 0) begin
      wait_tick(ch, ok);
      if (!ok) return;
      pbit = tx[ch];
    end
    for (int s = 0; s < sb; s++) begin
      wait_tick(ch, ok);
      if (!ok) return;
      chk("stop_bit", ch, tx[ch], 1);
    end
    wait_tick(ch, ok);
    if (!ok) return;
    chk("done_at_end", ch, tx_done[ch], 1);
    chk("frame_ticks", ch, tick_no - st, 1 + db + ((par != 0) ? 1 : 0) + sb);
    if (exp_q[ch].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame ch%0d: got word %0h, expected no frame", ch, data);
    end else begin
      e = exp_q[ch].pop_front();
      chk("frame_data", ch, data, e);
      if (par != 0) chk("parity", ch, pbit, (par == 1) ? ^e : ~^e);
    end
    last_end[ch] = tick_no;
  endtask

  task automatic monitor(input int ch);
    forever begin
      do begin
        @(posedge clk);
        #1;
      end while (!(tick_now && (tx[ch] === 1'b0)));
      last_gap[ch] = tick_no - last_end[ch];
      rx_frame(ch);
      // A start bit on the very tick that ended the previous frame.
      while (rst && (tx[ch] === 1'b0) && (last_end[ch] == tick_no)) begin
        last_gap[ch] = 0;
        rx_frame(ch);
      end
    end
  endtask

  task automatic send(input int ch, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (din_rdy[ch] !== 1'b1) begin
      if (n > 3000) begin
        bound_fail("send_wait", ch);
        return;
      end
      @(negedge clk);
      n++;
    end
    din_a[ch]   = b;
    din_vld[ch] = 1'b1;
    exp_q[ch].push_back(b & mask_of(ch));
    sent[ch]++;
    @(negedge clk);
    din_vld[ch] = 1'b0;
    din_a[ch]   = 8'($urandom);
    chk("rdy_after_take", ch, din_rdy[ch], 0);
  endtask

  // Offers a word while the holding register is full; it must be dropped.
  task automatic poke(input int ch);
    @(negedge clk);
    if (din_rdy[ch] === 1'b0) begin
      din_a[ch]   = 8'($urandom);
      din_vld[ch] = 1'b1;
      @(negedge clk);
      din_vld[ch] = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 0, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic rnd(input int ch);
    repeat (15) begin
      repeat ($urandom_range(20, 0)) @(negedge clk);
      send(ch, 8'($urandom));
      if ($urandom_range(1, 0) == 1) poke(ch);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    int         s;
    bit         ok;
    logic [2:0] snap;
    logic [7:0] loop_bytes [4];

    rst     = 1'b0;
    din_vld = 3'b000;
    for (int c = 0; c < 3; c++) din_a[c] = 8'h00;

    // Reset held while bclk toggles.
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 3'b111 || tx_busy !== 3'b000 || din_rdy !== 3'b111 || tx_done !== 3'b000) bad++;
    end
    chk("reset_hold", 0, bad, 0);
    for (int c = 0; c < 3; c++) begin
      chk("reset_tx", c, tx[c], 1);
      chk("reset_rdy", c, din_rdy[c], 1);
      chk("reset_busy", c, tx_busy[c], 0);
      chk("reset_done", c, tx_done[c], 0);
    end

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    @(negedge clk);
    rst = 1'b1;

    // Single frame, default format.
    send(0, 8'hA5);
    drain();

    // Second word queued while the first is on the line: no idle bit between frames.
    send(0, 8'h3C);
    send(0, 8'hC3);
    drain();
    chk("b2b_gap", 0, last_gap[0], 0);

    // Parity formats.
    send(1, 8'h07);
    send(2, 8'h07);
    drain();

    // Loopback patterns on every channel at once.
    loop_bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      fork
        send(0, loop_bytes[i]);
        send(1, loop_bytes[i]);
        send(2, loop_bytes[i]);
      join
    end
    drain();

    // Reset in the middle of data bit 4 with a word queued behind it.
    send(0, 8'hFF);
    send(0, 8'h12);
    for (int i = 0; i < 4; i++) wait_tick(0, ok);
    #2;
    chk("busy_before_reset", 0, tx_busy[0], 1);
    chk("rdy_before_reset", 0, din_rdy[0], 0);
    rst = 1'b0;
    #1;
    chk("async_reset_tx", 0, tx[0], 1);
    chk("async_reset_rdy", 0, din_rdy[0], 1);
    chk("async_reset_busy", 0, tx_busy[0], 0);
    exp_q[0].delete();
    lost[0] += 2;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    s = started[0];
    repeat (80) @(negedge clk);
    chk("no_frame_after_reset", 0, started[0], s);
    chk("idle_after_reset_tx", 0, tx[0], 1);
    send(0, 8'h5A);
    drain();

    // Random traffic, with the baud clock frozen for a while mid-stream.
    fork
      rnd(0);
      rnd(1);
      rnd(2);
      begin
        repeat (300) @(negedge clk);
        bclk_freeze = 1'b1;
        repeat (2) @(negedge clk);
        snap = tx;
        repeat (55) @(negedge clk);
        chk("freeze_hold", 0, tx, snap);
        bclk_freeze = 1'b0;
      end
    join
    drain();

    for (int c = 0; c < 3; c++) chk("done_pulses", c, done_cnt[c], sent[c] - lost[c]);
    chk("line_stable_between_ticks", 0, glitch, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
